// File: rtl/node_controller_ts_if.sv
// rtl/node_controller_ts_if.sv - packet, node-info and control signal bundle for node_controller_ts
interface node_controller_ts_if #(parameter int WORD_WIDTH = 16);
    logic                  newpkt;
    logic [2:0]            fPacketType;
    logic [WORD_WIDTH-1:0] fHopsFromCH;
    logic [WORD_WIDTH-1:0] fChosenCH;
    logic [WORD_WIDTH-1:0] fTimeslot;
    logic [WORD_WIDTH-1:0] destinationID;
    logic                  channel_clear;
    logic [WORD_WIDTH-1:0] myTimeslot;
    logic [WORD_WIDTH-1:0] myNodeID;
    logic                  role;
    logic                  iHaveData;
    logic [WORD_WIDTH-1:0] chosenCH;
    logic                  en_KCH;
    logic                  en_MNI;
    logic                  en_QTU_FMB;
    logic                  en_neighborTable;
    logic                  en_reward;
    logic                  iAmDestination;
    logic                  okToSend;
    logic                  txTimeout;
    logic                  pktDropped;
    logic                  busy;
    logic [WORD_WIDTH-1:0] slotCount;

    modport master (
        output newpkt, fPacketType, fHopsFromCH, fChosenCH, fTimeslot, destinationID,
               channel_clear, myTimeslot, myNodeID, role, iHaveData, chosenCH,
        input  en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward,
               iAmDestination, okToSend, txTimeout, pktDropped, busy, slotCount
    );

    modport slave (
        input  newpkt, fPacketType, fHopsFromCH, fChosenCH, fTimeslot, destinationID,
               channel_clear, myTimeslot, myNodeID, role, iHaveData, chosenCH,
        output en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward,
               iAmDestination, okToSend, txTimeout, pktDropped, busy, slotCount
    );
endinterface

// File: rtl/node_controller_ts.sv
// rtl/node_controller_ts.sv - EER-RL node controller: packet decode, TDMA slot timer, CCA-gated TX
module node_controller_ts #(
    parameter int WORD_WIDTH  = 16,
    parameter int MAX_HOPS    = 4,
    parameter int SLOT_LEN    = 32,
    parameter int NUM_SLOTS   = 16,
    parameter int CCA_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    node_controller_ts_if.slave  bus
);
    localparam int W  = WORD_WIDTH;
    localparam int CW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int TW = (CCA_TIMEOUT > 1) ? $clog2(CCA_TIMEOUT) : 1;

    localparam logic [2:0] T_HB = 3'd0, T_CHE = 3'd1, T_INV = 3'd2, T_MR = 3'd3,
                           T_CHT = 3'd4, T_DATA = 3'd5, T_SOS = 3'd6;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_UPDATE, S_WAIT_CCA, S_SEND} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [W-1:0]    slot_q, slot_d;
    logic [TW-1:0]   cca_q, cca_d;
    logic            fwd_q, fwd_d;
    logic [2:0]      type_q, type_d;
    logic [W-1:0]    hops_q, hops_d, chosen_q, chosen_d, dest_q, dest_d;
    logic            hops_ok_q, hops_ok_d, ch_match_q, ch_match_d, dest_match_q, dest_match_d;
    logic            en_kch_q, en_kch_d, en_mni_q, en_mni_d, en_qtu_q, en_qtu_d;
    logic            en_nt_q, en_nt_d, en_rew_q, en_rew_d, iam_q, iam_d;
    logic            ok_q, ok_d, tmo_q, tmo_d, drop_q, drop_d, busy_q, busy_d;
    logic            tx_trigger, cca_expired;
    logic            unused_fts;

    // The packet timeslot is consumed by MNI downstream, not by this block.
    assign unused_fts = ^bus.fTimeslot;

    assign tx_trigger  = (bus.iHaveData | fwd_q) && (bus.myTimeslot != '1) &&
                         (slot_q == bus.myTimeslot);
    assign cca_expired = (cca_q == TW'(CCA_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (bus.newpkt)       state_d = S_DECODE;
                        else if (tx_trigger)  state_d = S_WAIT_CCA;
            S_DECODE:   state_d = S_UPDATE;
            S_UPDATE:   state_d = (type_q == T_INV && hops_ok_q) ? S_WAIT_CCA : S_IDLE;
            S_WAIT_CCA: if (bus.channel_clear) state_d = S_SEND;
                        else if (cca_expired)  state_d = S_IDLE;
            S_SEND:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        en_kch_d = 1'b0; en_mni_d = 1'b0; en_qtu_d = 1'b0; en_nt_d = 1'b0; en_rew_d = 1'b0;
        iam_d    = 1'b0; ok_d     = 1'b0; tmo_d    = 1'b0;
        drop_d   = bus.newpkt && (state_q != S_IDLE);
        busy_d   = (state_d != S_IDLE);
        case (state_q)
            S_UPDATE: begin
                case (type_q)
                    T_HB:   en_nt_d  = 1'b1;
                    T_CHE:  en_mni_d = 1'b1;
                    T_INV:  en_kch_d = hops_ok_q;
                    T_MR:   en_nt_d  = ch_match_q;
                    T_CHT:  begin en_mni_d = dest_match_q; iam_d = dest_match_q; end
                    T_DATA: begin
                        iam_d    = dest_match_q;
                        en_rew_d = dest_match_q;
                        en_qtu_d = dest_match_q;
                    end
                    T_SOS:  begin en_qtu_d = 1'b1; en_rew_d = 1'b1; end
                    default: ;
                endcase
            end
            S_WAIT_CCA: tmo_d = !bus.channel_clear && cca_expired;
            S_SEND:     ok_d  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cyc_d  = cyc_q + CW'(1);
        slot_d = slot_q;
        if (cyc_q == CW'(SLOT_LEN - 1)) begin
            cyc_d  = '0;
            slot_d = (slot_q == W'(NUM_SLOTS - 1)) ? '0 : slot_q + W'(1);
        end
        type_d = type_q; hops_d = hops_q; chosen_d = chosen_q; dest_d = dest_q;
        if (state_q == S_IDLE && bus.newpkt) begin
            type_d   = bus.fPacketType;
            hops_d   = bus.fHopsFromCH;
            chosen_d = bus.fChosenCH;
            dest_d   = bus.destinationID;
        end
        hops_ok_d = hops_ok_q; ch_match_d = ch_match_q; dest_match_d = dest_match_q;
        if (state_q == S_DECODE) begin
            hops_ok_d    = (hops_q < W'(MAX_HOPS));
            ch_match_d   = (chosen_q == bus.chosenCH);
            dest_match_d = (dest_q == bus.myNodeID);
        end
        cca_d = cca_q;
        if (state_q != S_WAIT_CCA && state_d == S_WAIT_CCA) cca_d = '0;
        else if (state_q == S_WAIT_CCA && !bus.channel_clear) cca_d = cca_q + TW'(1);
        // A timed-out forward stays pending so the next frame's slot retries it.
        fwd_d = fwd_q;
        if (state_q == S_UPDATE && type_q == T_DATA && dest_match_q && !bus.role) fwd_d = 1'b1;
        if (state_q == S_SEND) fwd_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0; slot_q <= '0; cca_q <= '0; fwd_q <= 1'b0;
            type_q <= '0; hops_q <= '0; chosen_q <= '0; dest_q <= '0;
            hops_ok_q <= 1'b0; ch_match_q <= 1'b0; dest_match_q <= 1'b0;
            en_kch_q <= 1'b0; en_mni_q <= 1'b0; en_qtu_q <= 1'b0; en_nt_q <= 1'b0;
            en_rew_q <= 1'b0; iam_q <= 1'b0; ok_q <= 1'b0; tmo_q <= 1'b0;
            drop_q <= 1'b0; busy_q <= 1'b0;
        end else begin
            cyc_q <= cyc_d; slot_q <= slot_d; cca_q <= cca_d; fwd_q <= fwd_d;
            type_q <= type_d; hops_q <= hops_d; chosen_q <= chosen_d; dest_q <= dest_d;
            hops_ok_q <= hops_ok_d; ch_match_q <= ch_match_d; dest_match_q <= dest_match_d;
            en_kch_q <= en_kch_d; en_mni_q <= en_mni_d; en_qtu_q <= en_qtu_d; en_nt_q <= en_nt_d;
            en_rew_q <= en_rew_d; iam_q <= iam_d; ok_q <= ok_d; tmo_q <= tmo_d;
            drop_q <= drop_d; busy_q <= busy_d;
        end
    end

    assign bus.en_KCH           = en_kch_q;
    assign bus.en_MNI           = en_mni_q;
    assign bus.en_QTU_FMB       = en_qtu_q;
    assign bus.en_neighborTable = en_nt_q;
    assign bus.en_reward        = en_rew_q;
    assign bus.iAmDestination   = iam_q;
    assign bus.okToSend         = ok_q;
    assign bus.txTimeout        = tmo_q;
    assign bus.pktDropped       = drop_q;
    assign bus.busy             = busy_q;
    assign bus.slotCount        = slot_q;
endmodule
